// File: rtl/status_register_bank.sv
// Bank of read/modify/write status registers with change pulses
// and a circular history of prior register-0 values.
module status_register_bank #(
  parameter int WIDTH      = 8,
  parameter int NUM_REGS   = 4,
  parameter int HIST_DEPTH = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(HIST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [1:0]       write_mode,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] current_state,
  output logic             change_pulse,
  output logic [AW-1:0]    change_addr,
  input  logic             hist_rd_en,
  output logic [WIDTH-1:0] hist_data,
  output logic [CW-1:0]    hist_count,
  output logic             hist_empty,
  output logic             hist_full,
  output logic             hist_overflow
);

  localparam int PW = $clog2(HIST_DEPTH);
  localparam logic [AW:0]   NR       = (AW+1)'(NUM_REGS);
  localparam logic [CW-1:0] FULL_CNT = CW'(HIST_DEPTH);
  localparam logic [PW-1:0] LAST     = PW'(HIST_DEPTH - 1);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] mem  [HIST_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             ovf;

  logic             rd_ok, wr_hit, changed, push, pop;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic [WIDTH-1:0] old_val, new_val;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ok   = {1'b0, read_addr} < NR;
    rd_idx  = rd_ok ? read_addr : '0;
    wr_hit  = write_en && ({1'b0, write_addr} < NR);
    wr_idx  = wr_hit ? write_addr : '0;
    old_val = regs[wr_idx];
    new_val = write_data;
    unique case (write_mode)
      2'b00: new_val = write_data;
      2'b01: new_val = old_val | write_data;
      2'b10: new_val = old_val & ~write_data;
      2'b11: new_val = old_val ^ write_data;
    endcase
    changed = wr_hit && (new_val != old_val);
    push    = changed && (wr_idx == '0);
    pop     = hist_rd_en && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      change_pulse <= 1'b0;
      change_addr  <= '0;
    end else begin
      change_pulse <= changed;
      if (changed) begin
        regs[wr_idx] <= new_val;
        change_addr  <= wr_idx;
      end
    end
  end

  // A push onto a full buffer without a pop drops the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (push) begin
      wptr <= nxt(wptr);
      if (pop) begin
        rptr <= nxt(rptr);
      end else if (count == FULL_CNT) begin
        rptr <= nxt(rptr);
        ovf  <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (pop) begin
      rptr  <= nxt(rptr);
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= old_val;
  end

  assign read_data     = rd_ok ? regs[rd_idx] : '0;
  assign current_state = regs[0];
  assign hist_count    = count;
  assign hist_empty    = (count == '0);
  assign hist_full     = (count == FULL_CNT);
  assign hist_overflow = ovf;
  assign hist_data     = hist_empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_status_register_bank.sv
// Scoreboard bench for status_register_bank: model results are queued
// at drive time and popped when the DUT outputs settle after the edge.
module tb_status_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [1:0] write_addr;
  logic [1:0] write_mode;
  logic [7:0] write_data;
  logic [1:0] read_addr;
  logic [7:0] read_data;
  logic [7:0] current_state;
  logic       change_pulse;
  logic [1:0] change_addr;
  logic       hist_rd_en;
  logic [7:0] hist_data;
  logic [2:0] hist_count;
  logic       hist_empty;
  logic       hist_full;
  logic       hist_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rd;
    logic [7:0] cs;
    logic       pulse;
    logic [1:0] caddr;
    logic [2:0] cnt;
    logic [7:0] hd;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_regs[4];
  logic [7:0] m_hist[$];
  logic       m_ovf;
  logic [1:0] m_caddr;

  status_register_bank #(
    .WIDTH(8), .NUM_REGS(4), .HIST_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr),
    .write_mode(write_mode), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data),
    .current_state(current_state),
    .change_pulse(change_pulse), .change_addr(change_addr),
    .hist_rd_en(hist_rd_en), .hist_data(hist_data),
    .hist_count(hist_count), .hist_empty(hist_empty),
    .hist_full(hist_full), .hist_overflow(hist_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_hist.delete();
    m_ovf   = 1'b0;
    m_caddr = 2'd0;
    exp_q.delete();
  endtask

  // Model the edge, queue the expectation, then apply it to the DUT.
  task automatic drive(input logic we, input logic [1:0] a,
                       input logic [1:0] mode, input logic [7:0] d,
                       input logic pop);
    exp_t e;
    logic [7:0] old_v, new_v;
    logic ch;
    ch    = 1'b0;
    old_v = m_regs[a];
    new_v = old_v;
    if (we) begin
      case (mode)
        2'b00:   new_v = d;
        2'b01:   new_v = old_v | d;
        2'b10:   new_v = old_v & ~d;
        default: new_v = old_v ^ d;
      endcase
      ch = (new_v != old_v);
      m_regs[a] = new_v;
    end
    if (pop && m_hist.size() > 0) void'(m_hist.pop_front());
    if (ch && a == 2'd0) begin
      if (m_hist.size() == 4) begin
        void'(m_hist.pop_front());
        m_ovf = 1'b1;
      end
      m_hist.push_back(old_v);
    end
    if (ch) m_caddr = a;
    e.rd    = m_regs[a];
    e.cs    = m_regs[0];
    e.pulse = ch;
    e.caddr = m_caddr;
    e.cnt   = 3'(m_hist.size());
    e.hd    = (m_hist.size() > 0) ? m_hist[0] : 8'h00;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    write_en   = we;
    write_addr = a;
    write_mode = mode;
    write_data = d;
    read_addr  = a;
    hist_rd_en = pop;
    @(posedge clk);
    #1;
    write_en   = 1'b0;
    hist_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write_en = 1'b0; write_addr = 2'd0; write_mode = 2'd0;
    write_data = 8'h00; read_addr = 2'd0; hist_rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      read_addr = 2'(i);
      #1;
      checks++;
      if (read_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h want 00", i, read_data);
      end
    end
    checks++;
    if (hist_empty !== 1'b1 || change_pulse !== 1'b0 ||
        hist_full !== 1'b0 || hist_overflow !== 1'b0 ||
        hist_count !== 3'd0 || hist_data !== 8'h00 ||
        change_addr !== 2'd0 || current_state !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: empty=%b pulse=%b full=%b ovf=%b cnt=%0d hd=%h ca=%0d cs=%h want 1 0 0 0 0 00 0 00",
               hist_empty, change_pulse, hist_full, hist_overflow,
               hist_count, hist_data, change_addr, current_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [1:0] modes [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] datas [4] = '{8'h01, 8'h02, 8'h01, 8'hFF};
    logic [7:0] states[4] = '{8'h01, 8'h03, 8'h02, 8'hFD};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, modes[i], datas[i], 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (current_state !== states[i] || current_state !== e.cs ||
          change_pulse !== e.pulse || change_addr !== e.caddr ||
          hist_count !== e.cnt || hist_data !== e.hd ||
          read_data !== e.rd) begin
        errors++;
        $display("FAIL modes[%0d]: cs=%h/%h pulse=%b/%b ca=%0d/%0d cnt=%0d/%0d hd=%h/%h rd=%h/%h",
                 i, current_state, states[i], change_pulse, e.pulse,
                 change_addr, e.caddr, hist_count, e.cnt,
                 hist_data, e.hd, read_data, e.rd);
      end
    end
    checks++;
    if (hist_full !== 1'b1 || hist_data !== 8'h00 ||
        hist_overflow !== 1'b0) begin
      errors++;
      $display("FAIL modes_hist: full=%b hd=%h ovf=%b want 1 00 0",
               hist_full, hist_data, hist_overflow);
    end
  endtask

  task automatic test_no_change();
    logic exp_pulse [2] = '{1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd2, 2'b00, 8'h5A, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (change_pulse !== exp_pulse[i] || change_pulse !== e.pulse ||
          change_addr !== 2'd2 || read_data !== 8'h5A ||
          hist_count !== e.cnt || hist_data !== e.hd ||
          current_state !== e.cs) begin
        errors++;
        $display("FAIL no_change[%0d]: pulse=%b/%b ca=%0d/2 rd=%h/5a cnt=%0d/%0d hd=%h/%h cs=%h/%h",
                 i, change_pulse, exp_pulse[i], change_addr, read_data,
                 hist_count, e.cnt, hist_data, e.hd,
                 current_state, e.cs);
      end
    end
  endtask

  task automatic test_overflow_pop();
    logic [7:0] pops [4] = '{8'h01, 8'h03, 8'h02, 8'hFD};
    exp_t e;
    drive(1'b1, 2'd0, 2'b00, 8'h10, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (hist_data !== 8'h01 || hist_count !== 3'd4 ||
        hist_overflow !== 1'b1 || hist_data !== e.hd ||
        hist_overflow !== e.ovf || change_pulse !== 1'b1 ||
        current_state !== 8'h10) begin
      errors++;
      $display("FAIL overflow: hd=%h/01 cnt=%0d/4 ovf=%b/1 pulse=%b/1 cs=%h/10",
               hist_data, hist_count, hist_overflow,
               change_pulse, current_state);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i < 4 && hist_data !== pops[i]) begin
        errors++;
        $display("FAIL pop_data[%0d]: got %h want %h",
                 i, hist_data, pops[i]);
      end
      drive(1'b0, 2'd0, 2'b00, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (hist_count !== e.cnt || hist_data !== e.hd ||
          hist_empty !== (e.cnt == 3'd0) ||
          hist_overflow !== 1'b1 || change_pulse !== 1'b0) begin
        errors++;
        $display("FAIL pop[%0d]: cnt=%0d/%0d hd=%h/%h empty=%b ovf=%b pulse=%b",
                 i, hist_count, e.cnt, hist_data, e.hd,
                 hist_empty, hist_overflow, change_pulse);
      end
    end
    checks++;
    if (hist_count !== 3'd0 || hist_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: cnt=%0d/0 empty=%b/1",
               hist_count, hist_empty);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] vals [2] = '{8'h20, 8'h30};
    logic [7:0] hds  [2] = '{8'h10, 8'h20};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 2'b00, vals[i], 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (hist_count !== 3'd1 || hist_data !== hds[i] ||
          hist_count !== e.cnt || hist_data !== e.hd ||
          current_state !== vals[i] || change_pulse !== 1'b1) begin
        errors++;
        $display("FAIL push_pop[%0d]: cnt=%0d/1 hd=%h/%h cs=%h/%h pulse=%b/1",
                 i, hist_count, hist_data, hds[i],
                 current_state, vals[i], change_pulse);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, 2'b11, 8'h81, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (change_pulse !== 1'b1 || change_addr !== 2'd1 ||
          read_data !== e.rd || hist_count !== e.cnt ||
          current_state !== e.cs) begin
        errors++;
        $display("FAIL b2b[%0d]: pulse=%b/1 ca=%0d/1 rd=%h/%h cnt=%0d/%0d",
                 i, change_pulse, change_addr, read_data, e.rd,
                 hist_count, e.cnt);
      end
    end
    drive(1'b0, 2'd0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (change_pulse !== 1'b0 || change_addr !== 2'd1) begin
      errors++;
      $display("FAIL b2b_idle: pulse=%b/0 ca=%0d/1",
               change_pulse, change_addr);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    write_en = 1'b1; write_addr = 2'd0; write_mode = 2'b00;
    write_data = 8'h77; hist_rd_en = 1'b1; read_addr = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (current_state !== 8'h00 || read_data !== 8'h00 ||
        change_pulse !== 1'b0 || change_addr !== 2'd0 ||
        hist_count !== 3'd0 || hist_empty !== 1'b1 ||
        hist_full !== 1'b0 || hist_overflow !== 1'b0 ||
        hist_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: cs=%h rd=%h pulse=%b ca=%0d cnt=%0d empty=%b full=%b ovf=%b hd=%h",
               current_state, read_data, change_pulse, change_addr,
               hist_count, hist_empty, hist_full, hist_overflow,
               hist_data);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0; hist_rd_en = 1'b0;
    checks++;
    if (current_state !== 8'h00 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: cs=%h/00 pulse=%b/0",
               current_state, change_pulse);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'd0, 2'b00, 8'h07, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (current_state !== 8'h07 || change_pulse !== 1'b1 ||
        hist_count !== 3'd1 || hist_data !== 8'h00 ||
        hist_count !== e.cnt || current_state !== e.cs) begin
      errors++;
      $display("FAIL first_write: cs=%h/07 pulse=%b/1 cnt=%0d/1 hd=%h/00",
               current_state, change_pulse, hist_count, hist_data);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_no_change();
    test_overflow_pop();
    test_push_pop();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
